mmio_write_sink: RTL and testbench

//  Consumes the CPU-side MMIO request port of the tiny SoC. Rocket only ever writes MMIO.
//  - Accepted writes are buffered in a FIFO and drained by the testbench over a valid/ready port.
//  - A write to StopAddr raises a sticky stop flag.
//  - Any read request is flagged as an error and never enqueued.
//  - Returns constant read data so the core's MMIO port is always terminated.

---
 rtl/mmio_write_sink_if.sv | 54 +++++
 rtl/mmio_write_sink.sv | 152 +++++++++++++++
 tb/tb_mmio_write_sink.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_write_sink_if.sv
// MMIO request port and FIFO drain port of the write sink.
// Optional feature macro: MMIO_SINK_TS_EN adds the TsWidth parameter and the
// out_ts_o head timestamp signal.
interface mmio_write_sink_if #(
    parameter int AddrWidth = 31,
    parameter int DataWidth = 64,
    parameter int StrbWidth = 8
`ifdef MMIO_SINK_TS_EN
    ,
    parameter int TsWidth   = 32
`endif
);
    // CPU-side MMIO request
    logic                 mmio_req_i;
    logic                 mmio_we_i;
    logic [AddrWidth-1:0] mmio_addr_i;
    logic [DataWidth-1:0] mmio_wdata_i;
    logic [StrbWidth-1:0] mmio_strb_i;
    logic [DataWidth-1:0] mmio_rdata_o;

    // FIFO head / consumer handshake
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [AddrWidth-1:0] out_addr_o;
    logic [DataWidth-1:0] out_data_o;
    logic [StrbWidth-1:0] out_strb_o;
`ifdef MMIO_SINK_TS_EN
    logic [TsWidth-1:0]   out_ts_o;
`endif

`ifdef MMIO_SINK_TS_EN
    // Requester / consumer side
    modport master (
        output mmio_req_i, mmio_we_i, mmio_addr_i, mmio_wdata_i, mmio_strb_i, out_ready_i,
        input  mmio_rdata_o, out_valid_o, out_addr_o, out_data_o, out_strb_o, out_ts_o
    );
    // Sink side
    modport slave (
        input  mmio_req_i, mmio_we_i, mmio_addr_i, mmio_wdata_i, mmio_strb_i, out_ready_i,
        output mmio_rdata_o, out_valid_o, out_addr_o, out_data_o, out_strb_o, out_ts_o
    );
`else
    // Requester / consumer side
    modport master (
        output mmio_req_i, mmio_we_i, mmio_addr_i, mmio_wdata_i, mmio_strb_i, out_ready_i,
        input  mmio_rdata_o, out_valid_o, out_addr_o, out_data_o, out_strb_o
    );
    // Sink side
    modport slave (
        input  mmio_req_i, mmio_we_i, mmio_addr_i, mmio_wdata_i, mmio_strb_i, out_ready_i,
        output mmio_rdata_o, out_valid_o, out_addr_o, out_data_o, out_strb_o
    );
`endif
endinterface

// File: rtl/mmio_write_sink.sv
// MMIO write sink: terminates the core's MMIO port, buffers every write in a
// first-word-fall-through FIFO for the bench to drain, raises a sticky stop
// flag on writes to StopAddr and a sticky error on any read.
// Optional feature macro: MMIO_SINK_TS_EN stores a free-running cycle
// timestamp with every entry and presents it on out_ts_o.
module mmio_write_sink #(
    parameter int                   AddrWidth = 31,
    parameter int                   DataWidth = 64,
    parameter int                   StrbWidth = 8,
    parameter int                   FifoDepth = 16,
    parameter logic [AddrWidth-1:0] StopAddr  = 'h0000100
`ifdef MMIO_SINK_TS_EN
    ,
    parameter int                   TsWidth   = 32
`endif
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    mmio_write_sink_if.slave               bus,
    output logic [$clog2(FifoDepth+1)-1:0] level_o,
    output logic                           stop_o,
    output logic [DataWidth-1:0]           stop_data_o,
    output logic                           overflow_o,
    output logic [15:0]                    drop_cnt_o,
    output logic                           read_err_o
);
    localparam int PtrW = $clog2(FifoDepth);
    localparam int LvlW = $clog2(FifoDepth + 1);
    localparam logic [LvlW-1:0] FullLevel = LvlW'(FifoDepth);

`ifdef MMIO_SINK_TS_EN
    localparam int TsBits = TsWidth;
`else
    localparam int TsBits = 0;
`endif
    // Entry layout, LSB first: [ts] strb data addr
    localparam int StrbLo = TsBits;
    localparam int DataLo = StrbLo + StrbWidth;
    localparam int AddrLo = DataLo + DataWidth;
    localparam int EntryW = AddrLo + AddrWidth;

    logic [EntryW-1:0] mem [FifoDepth];
    logic [EntryW-1:0] wr_entry;
    logic [EntryW-1:0] head_entry;

    logic [PtrW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LvlW-1:0] level_reg, level_next;
    logic            stop_reg, overflow_reg, read_err_reg;
    logic [DataWidth-1:0] stop_data_reg;
    logic [15:0]     drop_cnt_reg;

    logic push_req, read_req, is_stop, fifo_full, fifo_empty;
    logic push, pop, drop;

`ifdef MMIO_SINK_TS_EN
    logic [TsWidth-1:0] ts_reg;

    // Free-running cycle counter sampled into each pushed entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ts_reg <= '0;
        else       ts_reg <= ts_reg + TsWidth'(1);
    end
`endif

    // Request decode and FIFO accept/drop decisions
    always_comb begin
        push_req   = bus.mmio_req_i & bus.mmio_we_i;
        read_req   = bus.mmio_req_i & ~bus.mmio_we_i;
        is_stop    = push_req && (bus.mmio_addr_i == StopAddr);
        fifo_full  = (level_reg == FullLevel);
        fifo_empty = (level_reg == '0);
        pop        = ~fifo_empty & bus.out_ready_i;
        // A full FIFO still takes a write when the head leaves on the same edge
        push       = push_req & (~fifo_full | pop);
        drop       = push_req & fifo_full & ~pop;
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LvlW'(1);
            2'b01:   level_next = level_reg - LvlW'(1);
            default: level_next = level_reg;
        endcase
    end

    // Pack the incoming write into one storage word
    always_comb begin
`ifdef MMIO_SINK_TS_EN
        wr_entry = {bus.mmio_addr_i, bus.mmio_wdata_i, bus.mmio_strb_i, ts_reg};
`else
        wr_entry = {bus.mmio_addr_i, bus.mmio_wdata_i, bus.mmio_strb_i};
`endif
    end

    // Storage array; no reset so it maps onto distributed RAM
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_reg] <= wr_entry;
    end

    // Pointers and occupancy; pointers wrap naturally at FifoDepth
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
            level_reg <= level_next;
        end
    end

    // Sticky status flags and saturating drop counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stop_reg      <= 1'b0;
            stop_data_reg <= '0;
            overflow_reg  <= 1'b0;
            read_err_reg  <= 1'b0;
            drop_cnt_reg  <= '0;
        end else begin
            if (is_stop) begin
                stop_reg <= 1'b1;
                // First stop write wins
                if (!stop_reg) stop_data_reg <= bus.mmio_wdata_i;
            end
            if (read_req) read_err_reg <= 1'b1;
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    // Fall-through head: combinational read of the entry at the read pointer;
    // fields are forced to zero while empty so reset drives all outputs low
    assign head_entry       = mem[rd_ptr_reg];
    assign bus.out_valid_o  = ~fifo_empty;
    assign bus.out_addr_o   = fifo_empty ? '0 : head_entry[AddrLo +: AddrWidth];
    assign bus.out_data_o   = fifo_empty ? '0 : head_entry[DataLo +: DataWidth];
    assign bus.out_strb_o   = fifo_empty ? '0 : head_entry[StrbLo +: StrbWidth];
`ifdef MMIO_SINK_TS_EN
    assign bus.out_ts_o     = fifo_empty ? '0 : head_entry[0 +: TsWidth];
`endif
    assign bus.mmio_rdata_o = '0;

    assign level_o     = level_reg;
    assign stop_o      = stop_reg;
    assign stop_data_o = stop_data_reg;
    assign overflow_o  = overflow_reg;
    assign drop_cnt_o  = drop_cnt_reg;
    assign read_err_o  = read_err_reg;

endmodule

// File: tb/tb_mmio_write_sink.sv
// Self-checking bench for mmio_write_sink: directed scenarios plus random
// traffic, checked against a queue-based reference FIFO.
module tb_mmio_write_sink;
    localparam int AW    = 31;
    localparam int DW    = 64;
    localparam int SW    = 8;
    localparam int DEPTH = 16;
    localparam int TW    = 32;
    localparam logic [AW-1:0] STOP_ADDR = 31'h100;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

`ifdef MMIO_SINK_TS_EN
    mmio_write_sink_if #(.AddrWidth(AW), .DataWidth(DW), .StrbWidth(SW), .TsWidth(TW)) bus ();
`else
    mmio_write_sink_if #(.AddrWidth(AW), .DataWidth(DW), .StrbWidth(SW)) bus ();
`endif

    logic [4:0]    level_o;
    logic          stop_o;
    logic [DW-1:0] stop_data_o;
    logic          overflow_o;
    logic [15:0]   drop_cnt_o;
    logic          read_err_o;

`ifdef MMIO_SINK_TS_EN
    mmio_write_sink #(.AddrWidth(AW), .DataWidth(DW), .StrbWidth(SW), .FifoDepth(DEPTH),
                      .StopAddr(STOP_ADDR), .TsWidth(TW)) dut (
`else
    mmio_write_sink #(.AddrWidth(AW), .DataWidth(DW), .StrbWidth(SW), .FifoDepth(DEPTH),
                      .StopAddr(STOP_ADDR)) dut (
`endif
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus.slave),
        .level_o     (level_o),
        .stop_o      (stop_o),
        .stop_data_o (stop_data_o),
        .overflow_o  (overflow_o),
        .drop_cnt_o  (drop_cnt_o),
        .read_err_o  (read_err_o)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [TW-1:0] ts;
    } entry_t;

    // Reference model state
    entry_t        sb_q[$];
    int            exp_level;
    bit            exp_stop, exp_ovf, exp_rerr;
    logic [DW-1:0] exp_stop_data;
    int            exp_drop;
    logic [TW-1:0] ts_model;
    bit            mon_en;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req_v);
        end
    endtask

    task automatic model_clear();
        sb_q.delete();
        exp_level     = 0;
        exp_stop      = 0;
        exp_ovf       = 0;
        exp_rerr      = 0;
        exp_stop_data = '0;
        exp_drop      = 0;
        ts_model      = '0;
    endtask

    task automatic set_idle();
        bus.mmio_req_i   = 1'b0;
        bus.mmio_we_i    = 1'b0;
        bus.mmio_addr_i  = '0;
        bus.mmio_wdata_i = '0;
        bus.mmio_strb_i  = '0;
        bus.out_ready_i  = 1'b0;
    endtask

    // One clock of stimulus, called at posedge+1; the model is updated with
    // the effect of the edge it spans.
    task automatic drive(input bit req, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] strb, input bit ready);
        bit     wr, will_pop, accept;
        entry_t e;
        bus.mmio_req_i   = req;
        bus.mmio_we_i    = we;
        bus.mmio_addr_i  = addr;
        bus.mmio_wdata_i = data;
        bus.mmio_strb_i  = strb;
        bus.out_ready_i  = ready;
        wr       = req && we;
        will_pop = (exp_level != 0) && ready;
        accept   = wr && ((exp_level < DEPTH) || will_pop);
        e        = '{addr: addr, data: data, strb: strb, ts: ts_model};
        @(posedge clk_i);
        #1;
        if (accept) sb_q.push_back(e);
        exp_level = exp_level + (accept ? 1 : 0) - (will_pop ? 1 : 0);
        if (wr && !accept) begin
            exp_ovf = 1;
            if (exp_drop < 65535) exp_drop++;
        end
        if (wr && addr == STOP_ADDR) begin
            if (!exp_stop) exp_stop_data = data;
            exp_stop = 1;
        end
        if (req && !we) exp_rerr = 1;
        ts_model = ts_model + 1;
    endtask

    task automatic idle(input bit ready);
        drive(1'b0, 1'b0, '0, '0, '0, ready);
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input bit ready);
        drive(1'b1, 1'b1, addr, data, 8'hFF, ready);
    endtask

    // Reset mid-operation: outputs must clear before any clock edge
    task automatic reset_check();
        mon_en = 0;
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_valid",     bus.out_valid_o, 0);
        chk("rst_level",     level_o, 0);
        chk("rst_stop",      stop_o, 0);
        chk("rst_stop_data", stop_data_o, 0);
        chk("rst_overflow",  overflow_o, 0);
        chk("rst_drop_cnt",  drop_cnt_o, 0);
        chk("rst_read_err",  read_err_o, 0);
        model_clear();
        set_idle();
        @(posedge clk_i);
        #1;
        rst_i  = 1'b0;
        mon_en = 1;
    endtask

    // Monitor: compares DUT state against the model and pops the scoreboard
    // whenever the head is consumed
    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("out_valid", bus.out_valid_o, (exp_level != 0));
            chk("level",     level_o, exp_level);
            chk("stop",      stop_o, exp_stop);
            chk("stop_data", stop_data_o, exp_stop_data);
            chk("overflow",  overflow_o, exp_ovf);
            chk("drop_cnt",  drop_cnt_o, exp_drop);
            chk("read_err",  read_err_o, exp_rerr);
            chk("rdata",     bus.mmio_rdata_o, 0);
            if (exp_level != 0) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard: got empty queue expected an entry");
                end else begin
                    chk("head_addr", bus.out_addr_o, sb_q[0].addr);
                    chk("head_data", bus.out_data_o, sb_q[0].data);
                    chk("head_strb", bus.out_strb_o, sb_q[0].strb);
`ifdef MMIO_SINK_TS_EN
                    chk("head_ts",   bus.out_ts_o, sb_q[0].ts);
`endif
                    if (bus.out_ready_i) begin
                        $display("pop addr=%h data=%h strb=%h", sb_q[0].addr, sb_q[0].data, sb_q[0].strb);
                        void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            pct;
        int            n;
        rst_i  = 1'b1;
        mon_en = 0;
        set_idle();
        model_clear();
        @(posedge clk_i);
        #1;
        chk("init_valid", bus.out_valid_o, 0);
        chk("init_level", level_o, 0);
        chk("init_stop",  stop_o, 0);
        @(posedge clk_i);
        #1;
        rst_i  = 1'b0;
        mon_en = 1;

        // Single write, consumer always ready
        wr(31'h40, 64'hDEAD_BEEF, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // 17 writes with no consumer: one drop
        for (int i = 1; i <= 17; i++) wr(31'h200 + AW'(i), DW'(i), 1'b0);
        idle(1'b0);
        // Full: simultaneous push and pop, no drop
        wr(31'h300, 64'h55, 1'b1);
        n = 0;
        while (exp_level != 0 && n < 100) begin idle(1'b1); n++; end

        // Two stop writes: first data wins, both enqueued
        wr(STOP_ADDR, 64'h1, 1'b0);
        wr(STOP_ADDR, 64'h2, 1'b0);
        // Read request: error flag, nothing enqueued
        drive(1'b1, 1'b0, 31'h40, 64'hFFFF, 8'hFF, 1'b0);
        idle(1'b0);
        n = 0;
        while (exp_level != 0 && n < 100) begin idle(1'b1); n++; end

        // Five queued entries, then asynchronous reset
        for (int i = 0; i < 5; i++) wr(31'h80 + AW'(i), 64'hA0 + DW'(i), 1'b0);
        reset_check();

        // Writes three cycles apart (timestamps differ by 3 when enabled)
        wr(31'h44, 64'h11, 1'b0);
        idle(1'b0);
        idle(1'b0);
        wr(31'h48, 64'h22, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Random traffic with alternating consumer pressure
        for (int i = 0; i < 400; i++) begin
            a   = ($urandom_range(0, 7) == 0) ? STOP_ADDR : AW'($urandom);
            d   = {$urandom, $urandom};
            pct = ((i / 100) % 2 == 1) ? 85 : 30;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0, a, d,
                  SW'($urandom), $urandom_range(0, 99) < pct);
        end

        n = 0;
        while (exp_level != 0 && n < 100) begin idle(1'b1); n++; end
        chk("drain_level", exp_level, 0);
        @(negedge clk_i);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
